// File: rtl/wb_commit_checker.sv
// Writeback commit checker: matches a WB-stage commit stream against a loadable
// table of expected (instruction, destination, data) entries in program order.
module wb_commit_checker #(
  parameter int          WORD         = 64,
  parameter int          INST_SIZE    = 32,
  parameter int          REG_W        = 5,
  parameter int          DEPTH        = 16,
  parameter logic [31:0] TIMEOUT      = 32'd1_000_000,
  parameter bit          STOP_ON_FAIL = 1'b1,
  localparam int         IW           = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [INST_SIZE-1:0] cfg_inst,
  input  logic [REG_W-1:0]     cfg_reg,
  input  logic [WORD-1:0]      cfg_data,
  input  logic [IW:0]          cfg_count,
  input  logic                 start,
  input  logic                 wb_valid,
  input  logic [INST_SIZE-1:0] wb_inst,
  input  logic [REG_W-1:0]     wb_reg,
  input  logic [WORD-1:0]      wb_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           err_code,
  output logic [IW-1:0]        err_idx,
  output logic [WORD-1:0]      err_data,
  output logic [IW:0]          match_cnt,
  output logic [IW:0]          mismatch_cnt,
  output logic [31:0]          cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PASS, S_FAIL} state_t;

  localparam logic [IW:0]   CNT_ONE   = (IW+1)'(1);
  localparam logic [IW:0]   CNT_MAX   = '1;
  localparam logic [IW:0]   CNT_DEPTH = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] PTR_ONE   = IW'(1);
  localparam logic [31:0]   TO_LAST   = TIMEOUT - 32'd1;

  logic [INST_SIZE-1:0] exp_inst_mem [DEPTH];
  logic [REG_W-1:0]     exp_reg_mem  [DEPTH];
  logic [WORD-1:0]      exp_data_mem [DEPTH];

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW:0]     count_q, count_d;
  logic [IW:0]     match_cnt_q, match_cnt_d;
  logic [IW:0]     mismatch_cnt_q, mismatch_cnt_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [IW-1:0]   err_idx_q, err_idx_d;
  logic [WORD-1:0] err_data_q, err_data_d;

  logic trigger, fields_ok, last_entry, timeout_hit;

  // Table is writable only while no check is running; storage is not reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q != S_CHECK) begin
      exp_inst_mem[cfg_idx] <= cfg_inst;
      exp_reg_mem[cfg_idx]  <= cfg_reg;
      exp_data_mem[cfg_idx] <= cfg_data;
    end
  end

  assign trigger     = wb_valid && (wb_inst == exp_inst_mem[ptr_q]);
  assign fields_ok   = (wb_reg == exp_reg_mem[ptr_q]) && (wb_data == exp_data_mem[ptr_q]);
  assign last_entry  = ({1'b0, ptr_q} == (count_q - CNT_ONE));
  assign timeout_hit = (cycle_cnt_q == TO_LAST);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    err_code_d     = err_code_q;
    err_idx_d      = err_idx_q;
    err_data_d     = err_data_q;

    if (state_q != S_CHECK) begin
      if (start) begin
        count_d        = (cfg_count > CNT_DEPTH) ? CNT_DEPTH : cfg_count;
        ptr_d          = '0;
        match_cnt_d    = '0;
        mismatch_cnt_d = '0;
        cycle_cnt_d    = '0;
        err_code_d     = 2'd0;
        err_idx_d      = '0;
        err_data_d     = '0;
        state_d        = (count_d == '0) ? S_PASS : S_CHECK;
      end
    end else begin
      cycle_cnt_d = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
      if (trigger) begin
        if (fields_ok) begin
          match_cnt_d = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + CNT_ONE;
          if (last_entry) state_d = (mismatch_cnt_q == '0) ? S_PASS : S_FAIL;
          else            ptr_d   = ptr_q + PTR_ONE;
        end else begin
          mismatch_cnt_d = (mismatch_cnt_q == CNT_MAX) ? mismatch_cnt_q : mismatch_cnt_q + CNT_ONE;
          if (err_code_q == 2'd0) begin
            err_code_d = 2'd1;
            err_idx_d  = ptr_q;
            err_data_d = wb_data;
          end
          if (STOP_ON_FAIL || last_entry) state_d = S_FAIL;
          else                            ptr_d   = ptr_q + PTR_ONE;
        end
      end
      // A final trigger landing on the timeout cycle takes precedence.
      if (timeout_hit && !(trigger && last_entry)) begin
        state_d = S_FAIL;
        if (err_code_d == 2'd0) begin
          err_code_d = 2'd2;
          err_idx_d  = ptr_q;
          err_data_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      count_q        <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      cycle_cnt_q    <= '0;
      err_code_q     <= 2'd0;
      err_idx_q      <= '0;
      err_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      count_q        <= count_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
      err_code_q     <= err_code_d;
      err_idx_q      <= err_idx_d;
      err_data_q     <= err_data_d;
    end
  end

  assign busy         = (state_q == S_CHECK);
  assign pass         = (state_q == S_PASS);
  assign fail         = (state_q == S_FAIL);
  assign done         = pass || fail;
  assign err_code     = err_code_q;
  assign err_idx      = err_idx_q;
  assign err_data     = err_data_q;
  assign match_cnt    = match_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign cycle_cnt    = cycle_cnt_q;

endmodule
